// File: rtl/lif_neuron_param.sv
// lif_neuron_param: parametrised leaky-integrate-and-fire neuron.
// Masked synaptic sum plus shift-based leak feeds a saturating membrane
// potential. An INTEGRATE/FIRE/REFRACTORY FSM produces a registered one-cycle
// spike pulse.
// Optional feature macro: LIF_SPIKE_COUNT_EN adds a saturating 8-bit spike_count output.
module lif_neuron_param #(
  parameter int NUM_IN        = 4,
  parameter int IN_W          = 4,
  parameter int POT_W         = 10,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4,
  parameter int OUT_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [NUM_IN-1:0]      in_mask,
  input  logic [POT_W-1:0]       threshold,
  output logic                   spike,
  output logic [POT_W-1:0]       potential,
  output logic [OUT_W-1:0]       out,
  output logic [1:0]             state
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [7:0]             spike_count
`endif
);

  localparam int SUM_W = IN_W + $clog2(NUM_IN);
  localparam int NXT_W = POT_W + 1;
  localparam int CNT_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] REFRAC_LOAD = CNT_W'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);

  localparam logic [1:0] ST_INTEGRATE  = 2'd0;
  localparam logic [1:0] ST_FIRE       = 2'd1;
  localparam logic [1:0] ST_REFRACTORY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [POT_W-1:0] pot_q, pot_d;
  logic             spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-input masked terms, zero-extended to the full sum width.
  logic [NUM_IN-1:0][SUM_W-1:0] term;
  for (genvar g = 0; g < NUM_IN; g++) begin : g_term
    assign term[g] = in_mask[g] ? SUM_W'(in_data[g*IN_W +: IN_W]) : '0;
  end

  // Adder tree over masked inputs; width guarantees no overflow.
  logic [SUM_W-1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) sum = sum + term[i];
  end

  // Leak amount; LEAK_SHIFT==0 means no leak at all (not pot - pot).
  logic [POT_W-1:0] leak_amt;
  if (LEAK_SHIFT == 0) begin : g_noleak
    assign leak_amt = '0;
  end else begin : g_leak
    assign leak_amt = pot_q >> LEAK_SHIFT;
  end

  logic [POT_W-1:0] leaked;
  logic [NXT_W-1:0] nxt_wide;
  logic [POT_W-1:0] nxt;

  // One extra bit catches overflow; saturate to all-ones.
  always_comb begin
    leaked   = pot_q - leak_amt;
    nxt_wide = {1'b0, leaked} + NXT_W'(in_valid ? sum : '0);
    nxt      = nxt_wide[POT_W] ? '1 : nxt_wide[POT_W-1:0];
  end

  // Next-state logic for the fire / refractory state machine.
  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INTEGRATE: begin
        if (threshold != '0 && nxt >= threshold) begin
          pot_d   = '0;
          spike_d = 1'b1;
          state_d = ST_FIRE;
        end else begin
          pot_d = nxt;
        end
      end
      ST_FIRE: begin
        pot_d = '0;
        if (REFRAC_CYCLES > 0) begin
          state_d = ST_REFRACTORY;
          cnt_d   = REFRAC_LOAD;
        end else begin
          state_d = ST_INTEGRATE;
        end
      end
      ST_REFRACTORY: begin
        pot_d = '0;
        if (cnt_q == '0) state_d = ST_INTEGRATE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        // Encoding 3 is unreachable; recover cleanly.
        state_d = ST_INTEGRATE;
        pot_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INTEGRATE;
      pot_q   <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike     = spike_q;
  assign potential = pot_q;
  assign state     = state_q;
  assign out       = pot_q[POT_W-1 -: OUT_W];

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] scnt_q, scnt_d;

  // Count FIRE entries (spike rising), saturating at 255.
  always_comb begin
    scnt_d = scnt_q;
    if (spike_d && !spike_q && scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
  end

  // Spike counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) scnt_q <= '0;
    else     scnt_q <= scnt_d;
  end

  assign spike_count = scnt_q;
`endif

endmodule

// File: tb/tb_lif_neuron_param.sv
// Directed bench for lif_neuron_param: vector table on a default-parameter
// instance, hand sequences on a LEAK_SHIFT=0 instance for mask/saturation.
module tb_lif_neuron_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        rst, in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_mask;
  logic [9:0]  threshold;
  logic        spike;
  logic [9:0]  potential;
  logic [3:0]  out;
  logic [1:0]  state;

  // No-leak DUT
  logic        b_rst, b_valid;
  logic [15:0] b_data;
  logic [3:0]  b_mask;
  logic [9:0]  b_thr;
  logic        b_spike;
  logic [9:0]  b_pot;
  logic [3:0]  b_out;
  logic [1:0]  b_state;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] spike_count, b_spike_count;
`endif

  lif_neuron_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mask(in_mask), .threshold(threshold), .spike(spike),
    .potential(potential), .out(out), .state(state)
`ifdef LIF_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  lif_neuron_param #(.LEAK_SHIFT(0)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_data(b_data),
    .in_mask(b_mask), .threshold(b_thr), .spike(b_spike),
    .potential(b_pot), .out(b_out), .state(b_state)
`ifdef LIF_SPIKE_COUNT_EN
    , .spike_count(b_spike_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic [3:0]  mask;
    logic [9:0]  thr;
    logic [9:0]  pot;
    logic        sp;
    logic [1:0]  st;
  } vec_t;

  vec_t tv[26];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                              input logic [3:0] m, input logic [9:0] t,
                              input logic [9:0] p, input logic s, input logic [1:0] st);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.mask = m; x.thr = t;
    x.pot = p; x.sp = s; x.st = st;
    return x;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; threshold = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_mask = '0; b_thr = '0;

    //         rst vld data      mask  thr  pot  sp st
    tv[0]  = mk(1, 0, 16'h0000, 4'hF, 100,   0, 0, 0); // reset
    tv[1]  = mk(0, 1, 16'hFFFF, 4'hF, 100,  60, 0, 0);
    tv[2]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 1, 1); // 53+60=113 fires
    tv[3]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[4]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[5]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[6]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[7]  = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 0);
    tv[8]  = mk(0, 1, 16'hFFFF, 4'hF, 100,  60, 0, 0); // integration resumes
    tv[9]  = mk(0, 0, 16'hFFFF, 4'hF, 100,  53, 0, 0); // leak only
    tv[10] = mk(0, 0, 16'hFFFF, 4'hF, 100,  47, 0, 0);
    tv[11] = mk(0, 0, 16'hFFFF, 4'hF, 100,  42, 0, 0);
    tv[12] = mk(0, 0, 16'hFFFF, 4'hF, 100,  37, 0, 0);
    tv[13] = mk(0, 1, 16'hFFFF, 4'hF, 100,  93, 0, 0); // 33+60
    tv[14] = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 1, 1); // 82+60=142 fires
    tv[15] = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[16] = mk(0, 1, 16'hFFFF, 4'hF, 100,   0, 0, 2);
    tv[17] = mk(1, 1, 16'hFFFF, 4'hF, 100,   0, 0, 0); // reset mid-refractory
    tv[18] = mk(0, 1, 16'hFFFF, 4'hF, 100,  60, 0, 0);
    tv[19] = mk(0, 1, 16'hFFFF, 4'hF,   0, 113, 0, 0); // threshold 0: no fire
    tv[20] = mk(0, 1, 16'hFFFF, 4'hF,   0, 159, 0, 0);
    tv[21] = mk(0, 1, 16'hFFFF, 4'hF, 160,   0, 1, 1); // 140+60=200 >= 160
    tv[22] = mk(1, 0, 16'hFFFF, 4'hF, 100,   0, 0, 0);
    tv[23] = mk(0, 1, 16'hFFFF, 4'h0, 100,   0, 0, 0); // empty mask
    tv[24] = mk(0, 1, 16'hFFFF, 4'h1, 100,  15, 0, 0); // only in0
    tv[25] = mk(0, 1, 16'hFFFF, 4'h1, 100,  29, 0, 0); // 15-1+15

    for (int i = 0; i < 26; i++) begin
      rst = tv[i].rst; in_valid = tv[i].vld; in_data = tv[i].data;
      in_mask = tv[i].mask; threshold = tv[i].thr;
      step();
      check($sformatf("v%0d_pot", i), int'(potential), int'(tv[i].pot));
      check($sformatf("v%0d_spike", i), int'(spike), int'(tv[i].sp));
      check($sformatf("v%0d_state", i), int'(state), int'(tv[i].st));
      check($sformatf("v%0d_out", i), int'(out), int'(tv[i].pot >> 6));
    end

    // No-leak instance: mask and saturation
    step();
    check("b_reset_pot", int'(b_pot), 0);
    b_rst = 1'b0; b_valid = 1'b1; b_mask = 4'h1; b_data = 16'h0005; b_thr = '0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("b_acc%0d", i), int'(b_pot), 5 * i);
    end
    b_mask = 4'hF; b_data = 16'hFFFF;
    begin
      int spikes = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (b_spike) spikes++;
      end
      check("b_no_spike_thr0", spikes, 0);
    end
    check("b_sat_pot", int'(b_pot), 1023);
    check("b_sat_out", int'(b_out), 15);
    b_valid = 1'b0;
    step();
    check("b_hold_pot", int'(b_pot), 1023);
    b_thr = 10'd1023;
    step();
    check("b_maxthr_spike", int'(b_spike), 1);
    check("b_maxthr_pot", int'(b_pot), 0);
    check("b_maxthr_state", int'(b_state), 1);

`ifdef LIF_SPIKE_COUNT_EN
    rst = 1'b1; in_valid = 1'b1; in_mask = 4'hF; in_data = 16'hFFFF; threshold = 10'd1;
    step();
    check("sc_reset", int'(spike_count), 0);
    rst = 1'b0;
    begin
      int seen = 0;
      int cyc = 0;
      while (seen < 300 && cyc < 5000) begin
        step();
        cyc++;
        if (spike) begin
          seen++;
          if (seen == 3) check("sc_three", int'(spike_count), 3);
        end
      end
      check("sc_300_seen", seen, 300);
      check("sc_saturate", int'(spike_count), 255);
    end
    rst = 1'b1;
    step();
    check("sc_cleared", int'(spike_count), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
